// File: rtl/dotp_engine_share_sched_pkg.sv
// Shared constants and types for the dot-product engine share scheduler.
package dotp_engine_share_sched_pkg;

    localparam int LANES  = 8;
    localparam int ELEM_W = 8;
    localparam int PROD_W = 2 * ELEM_W + $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } sched_state_e;

endpackage

// File: rtl/dotp_engine_share_sched_if.sv
// Request, engine and result signals of the scheduler grouped in one bundle.
// "slave" is the scheduler's view, "master" is the surrounding environment.
interface dotp_engine_share_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ACC_W   = 32
);
    import dotp_engine_share_sched_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int VEC_W = LANES * ELEM_W;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ*VEC_W-1:0] req_vec_a;
    logic [NUM_REQ*VEC_W-1:0] req_vec_b;

    logic                     eng_compute;
    logic [VEC_W-1:0]         eng_vec_a;
    logic [VEC_W-1:0]         eng_vec_b;
    logic [PROD_W-1:0]        eng_dot_product;
    logic                     eng_out_valid;

    logic                     res_valid;
    logic                     res_ready;
    logic [ACC_W-1:0]         res_data;
    logic [IDX_W-1:0]         res_id;
    logic                     res_ovf;
    logic                     err_spurious;

    modport master (
        output req_valid, req_last, req_vec_a, req_vec_b,
        output eng_dot_product, eng_out_valid, res_ready,
        input  req_ready, eng_compute, eng_vec_a, eng_vec_b,
        input  res_valid, res_data, res_id, res_ovf, err_spurious
    );

    modport slave (
        input  req_valid, req_last, req_vec_a, req_vec_b,
        input  eng_dot_product, eng_out_valid, res_ready,
        output req_ready, eng_compute, eng_vec_a, eng_vec_b,
        output res_valid, res_data, res_id, res_ovf, err_spurious
    );

endinterface

// File: rtl/dotp_engine_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request searching upward from ptr+1.
module dotp_engine_share_sched_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_cand;

    // Rotating priority search; the candidate right after the last winner has top priority.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
            if (!o_any && i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end else begin
                o_any = o_any;
            end
        end
        if (o_any) begin
            o_grant[o_idx] = 1'b1;
        end else begin
            o_grant = '0;
        end
    end

endmodule

// File: rtl/dotp_engine_share_sched.sv
// Shares one pipelined dot-product engine among NUM_REQ requesters. A grant
// covers a whole transaction; beats are issued to the engine, returning
// per-beat results are summed, and the total is offered with the requester ID.
module dotp_engine_share_sched
    import dotp_engine_share_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ACC_W      = 32,
    parameter int ENGINE_LAT = 2
) (
    input logic                      clk,
    input logic                      rst,
    dotp_engine_share_sched_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ENGINE_LAT + 2);
    localparam int VEC_W = LANES * ELEM_W;
    localparam int SUM_W = ACC_W + 1;

    sched_state_e       r_state;
    sched_state_e       w_next_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [NUM_REQ-1:0] r_grant_oh;
    logic [CNT_W-1:0]   r_out_cnt;
    logic [CNT_W-1:0]   w_out_next;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic               r_err;
    logic               r_eng_compute;
    logic [VEC_W-1:0]   r_eng_vec_a;
    logic [VEC_W-1:0]   r_eng_vec_b;

    logic [VEC_W-1:0]   w_sel_a;
    logic [VEC_W-1:0]   w_sel_b;
    logic               w_accept;
    logic               w_last;
    logic               w_ret;
    logic               w_spur;
    logic               w_res_take;
    logic [SUM_W-1:0]   w_sum;

    logic [NUM_REQ-1:0] w_arb_grant;
    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_any;

    dotp_engine_share_sched_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    // Beat handshake, engine return classification and accumulator sum.
    always_comb begin
        w_accept   = (r_state == STREAM) && (|(bus.req_valid & r_grant_oh));
        w_last     = |(bus.req_last & r_grant_oh);
        w_ret      = bus.eng_out_valid && (r_out_cnt != '0);
        w_spur     = bus.eng_out_valid && (r_out_cnt == '0);
        w_res_take = (r_state == RESULT) && bus.res_ready;
        w_sum      = {1'b0, r_acc} + SUM_W'(bus.eng_dot_product);
    end

    // Operand mux: and-or select of the granted requester's vectors.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            w_sel_a = w_sel_a | (bus.req_vec_a[r*VEC_W +: VEC_W] & {VEC_W{r_grant_oh[r]}});
            w_sel_b = w_sel_b | (bus.req_vec_b[r*VEC_W +: VEC_W] & {VEC_W{r_grant_oh[r]}});
        end
    end

    // Outstanding-beat count after this cycle's issue and return.
    always_comb begin
        w_out_next = r_out_cnt;
        case ({w_accept, w_ret})
            2'b10:   w_out_next = r_out_cnt + CNT_W'(1);
            2'b01:   w_out_next = r_out_cnt - CNT_W'(1);
            default: w_out_next = r_out_cnt;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; DRAIN exits once the last result has been folded in.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_arb_any) w_next_state = STREAM;
                else           w_next_state = IDLE;
            end
            STREAM: begin
                if (w_accept && w_last) w_next_state = DRAIN;
                else                    w_next_state = STREAM;
            end
            DRAIN: begin
                if (w_out_next == '0) w_next_state = RESULT;
                else                  w_next_state = DRAIN;
            end
            RESULT: begin
                if (bus.res_ready) w_next_state = IDLE;
                else               w_next_state = RESULT;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs: beat accept only for the grant holder, result valid in RESULT.
    always_comb begin
        bus.req_ready = '0;
        bus.res_valid = 1'b0;
        case (r_state)
            STREAM:  bus.req_ready = r_grant_oh;
            RESULT:  bus.res_valid = 1'b1;
            default: begin
                bus.req_ready = '0;
                bus.res_valid = 1'b0;
            end
        endcase
    end

    // Grant latch, operand pipeline, outstanding counter, accumulator and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= IDX_W'(NUM_REQ - 1);
            r_grant_idx   <= '0;
            r_grant_oh    <= '0;
            r_out_cnt     <= '0;
            r_acc         <= '0;
            r_ovf         <= 1'b0;
            r_err         <= 1'b0;
            r_eng_compute <= 1'b0;
            r_eng_vec_a   <= '0;
            r_eng_vec_b   <= '0;
        end else begin
            if ((r_state == IDLE) && w_arb_any) begin
                r_rr_ptr    <= w_arb_idx;
                r_grant_idx <= w_arb_idx;
                r_grant_oh  <= w_arb_grant;
            end
            r_eng_compute <= w_accept;
            if (w_accept) begin
                r_eng_vec_a <= w_sel_a;
                r_eng_vec_b <= w_sel_b;
            end
            r_out_cnt <= w_out_next;
            if (w_res_take) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (w_ret) begin
                r_acc <= w_sum[ACC_W-1:0];
                if (w_sum[ACC_W]) r_ovf <= 1'b1;
            end
            if (w_spur) r_err <= 1'b1;
        end
    end

    assign bus.eng_compute  = r_eng_compute;
    assign bus.eng_vec_a    = r_eng_vec_a;
    assign bus.eng_vec_b    = r_eng_vec_b;
    assign bus.res_data     = r_acc;
    assign bus.res_id       = r_grant_idx;
    assign bus.res_ovf      = r_ovf;
    assign bus.err_spurious = r_err;

endmodule

// File: tb/tb_dotp_engine_share_sched.sv
// Bench for dotp_engine_share_sched: an 8-lane, 2-cycle engine model per DUT,
// a result scoreboard, a table of single-beat transactions and hand-written
// multi-cycle sequences. A second instance is built with ACC_W=19.
module tb_dotp_engine_share_sched;
    import dotp_engine_share_sched_pkg::*;

    localparam int VEC_W = LANES * ELEM_W;

    logic clk = 1'b0;
    logic rst;
    logic inj_spur;
    always #5 clk = ~clk;

    dotp_engine_share_sched_if #(.NUM_REQ(4), .ACC_W(32)) bus ();
    dotp_engine_share_sched_if #(.NUM_REQ(4), .ACC_W(19)) bus19 ();

    dotp_engine_share_sched #(.NUM_REQ(4), .ACC_W(32), .ENGINE_LAT(2)) u_dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    dotp_engine_share_sched #(.NUM_REQ(4), .ACC_W(19), .ENGINE_LAT(2)) u_dut19 (
        .clk (clk), .rst (rst), .bus (bus19)
    );

    function automatic logic [PROD_W-1:0] dot8(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
        logic [PROD_W-1:0] s;
        s = '0;
        for (int i = 0; i < LANES; i++)
            s = s + ({11'd0, a[i*ELEM_W +: ELEM_W]} * {11'd0, b[i*ELEM_W +: ELEM_W]});
        return s;
    endfunction

    // Engine models: two register stages, sharing the scheduler reset.
    logic s1_v, s2_v, t1_v, t2_v;
    logic [PROD_W-1:0] s1_d, s2_d, t1_d, t2_d;
    always @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0; s2_v <= 1'b0; s1_d <= '0; s2_d <= '0;
            t1_v <= 1'b0; t2_v <= 1'b0; t1_d <= '0; t2_d <= '0;
        end else begin
            s1_v <= bus.eng_compute;   s1_d <= dot8(bus.eng_vec_a, bus.eng_vec_b);
            s2_v <= s1_v;              s2_d <= s1_d;
            t1_v <= bus19.eng_compute; t1_d <= dot8(bus19.eng_vec_a, bus19.eng_vec_b);
            t2_v <= t1_v;              t2_d <= t1_d;
        end
    end
    assign bus.eng_out_valid     = s2_v | inj_spur;
    assign bus.eng_dot_product   = s2_d;
    assign bus19.eng_out_valid   = t2_v;
    assign bus19.eng_dot_product = t2_d;

    typedef struct { int id; longint data; int ovf; } exp_t;
    typedef struct { int id; logic [7:0] a; logic [7:0] b; longint exp; } vec_t;

    exp_t   exp_q[$];
    vec_t   tbl[6];
    int     n_pass = 0;
    int     n_total = 0;
    int     cyc_n = 0;
    int     rise_cyc = 0;
    int     first_acc = 0;
    int     last_acc = 0;
    logic   prev_rv = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    endtask

    task automatic score();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_result: actual id %0d data %0d, required no result", bus.res_id, bus.res_data);
        end else begin
            e = exp_q.pop_front();
            check("res_id", bus.res_id, e.id);
            check("res_data", bus.res_data, e.data);
            check("res_ovf", bus.res_ovf, e.ovf);
        end
    endtask

    // Advance to the next falling edge and score any result handshake due at the next rising edge.
    task automatic tick();
        @(negedge clk);
        cyc_n++;
        if (bus.res_valid && !prev_rv) rise_cyc = cyc_n;
        prev_rv = bus.res_valid;
        if (bus.res_valid && bus.res_ready) score();
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic send_txn(input int id, input int nb, input logic [7:0] a, input logic [7:0] b);
        int tmo;
        for (int k = 0; k < nb; k++) begin
            bus.req_valid[id] = 1'b1;
            bus.req_last[id]  = (k == nb - 1);
            bus.req_vec_a[id*VEC_W +: VEC_W] = {LANES{a}};
            bus.req_vec_b[id*VEC_W +: VEC_W] = {LANES{b}};
            tmo = 0;
            tick();
            while (!bus.req_ready[id] && tmo < 100) begin tick(); tmo++; end
            if (tmo >= 100) begin
                n_total++;
                $display("FAIL accept_timeout: requester %0d beat %0d not accepted, required accept", id, k);
                break;
            end
            if (k == 0) first_acc = cyc_n;
            last_acc = cyc_n;
            to_drive();
        end
        bus.req_valid[id] = 1'b0;
        bus.req_last[id]  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin tick(); t++; end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: actual %0d results pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic send19(input int nb, input logic [7:0] v);
        int tmo;
        for (int k = 0; k < nb; k++) begin
            bus19.req_valid[0] = 1'b1;
            bus19.req_last[0]  = (k == nb - 1);
            bus19.req_vec_a[VEC_W-1:0] = {LANES{v}};
            bus19.req_vec_b[VEC_W-1:0] = {LANES{v}};
            tmo = 0;
            tick();
            while (!bus19.req_ready[0] && tmo < 100) begin tick(); tmo++; end
            if (tmo >= 100) begin
                n_total++;
                $display("FAIL accept19_timeout: beat %0d not accepted, required accept", k);
                break;
            end
            to_drive();
        end
        bus19.req_valid[0] = 1'b0;
        bus19.req_last[0]  = 1'b0;
    endtask

    task automatic wait_res19();
        int tmo;
        tmo = 0;
        tick();
        while (!bus19.res_valid && tmo < 100) begin tick(); tmo++; end
        if (tmo >= 100) begin
            n_total++;
            $display("FAIL res19_timeout: actual no res_valid, required res_valid");
        end
    endtask

    initial begin
        int   n_acc;
        int   tmo;
        logic seen;

        tbl[0] = '{0, 8'd1,   8'd2,   64'd16};
        tbl[1] = '{1, 8'd3,   8'd5,   64'd120};
        tbl[2] = '{2, 8'd255, 8'd255, 64'd520200};
        tbl[3] = '{3, 8'd0,   8'd77,  64'd0};
        tbl[4] = '{1, 8'd10,  8'd20,  64'd1600};
        tbl[5] = '{0, 8'd128, 8'd2,   64'd2048};

        rst = 1'b1; inj_spur = 1'b0;
        bus.req_valid = '0; bus.req_last = '0; bus.req_vec_a = '0; bus.req_vec_b = '0; bus.res_ready = 1'b1;
        bus19.req_valid = '0; bus19.req_last = '0; bus19.req_vec_a = '0; bus19.req_vec_b = '0; bus19.res_ready = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_flags", {bus.res_valid, bus.req_ready, bus.eng_compute, bus.err_spurious, bus.res_ovf}, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_id", bus.res_id, 0);
        check("rst_eng_vec", {bus.eng_vec_a, bus.eng_vec_b} == '0, 1);
        check("rst19_flags", {bus19.res_valid, bus19.req_ready, bus19.res_data}, 0);
        to_drive(); rst = 1'b0;

        // Table of single-beat transactions with latency check
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{tbl[i].id, tbl[i].exp, 0});
            send_txn(tbl[i].id, 1, tbl[i].a, tbl[i].b);
            wait_drain();
            check("latency", rise_cyc - last_acc, 4);
        end

        // Three back-to-back beats from requester 2
        exp_q.push_back('{2, 64'd1560600, 0});
        send_txn(2, 3, 8'd255, 8'd255);
        check("b2b_accept_span", last_acc - first_acc, 2);
        wait_drain();
        check("b2b_latency", rise_cyc - last_acc, 4);

        // All four valid continuously from reset: grants 0,1,2,3,0
        rst = 1'b1; tick(); to_drive(); rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            bus.req_valid[r] = 1'b1; bus.req_last[r] = 1'b1;
            bus.req_vec_a[r*VEC_W +: VEC_W] = {LANES{8'(r + 1)}};
            bus.req_vec_b[r*VEC_W +: VEC_W] = {LANES{8'd2}};
        end
        for (int r = 0; r < 4; r++) exp_q.push_back('{r, longint'(16 * (r + 1)), 0});
        exp_q.push_back('{0, 64'd16, 0});
        n_acc = 0;
        for (int t = 0; t < 300 && n_acc < 5; t++) begin
            tick();
            if (|(bus.req_valid & bus.req_ready)) begin
                n_acc++;
                if (n_acc == 5) begin to_drive(); bus.req_valid = '0; bus.req_last = '0; end
            end
        end
        check("rr_beats_accepted", n_acc, 5);
        bus.req_valid = '0; bus.req_last = '0;
        wait_drain();

        // Result stall: res_ready low for 5 cycles while requester 1 waits
        to_drive(); bus.res_ready = 1'b0;
        exp_q.push_back('{3, 64'd160, 0});
        exp_q.push_back('{1, 64'd8, 0});
        send_txn(3, 1, 8'd4, 8'd5);
        tmo = 0;
        tick();
        while (!bus.res_valid && tmo < 50) begin tick(); tmo++; end
        bus.req_valid[1] = 1'b1; bus.req_last[1] = 1'b1;
        bus.req_vec_a[VEC_W +: VEC_W] = {LANES{8'd1}};
        bus.req_vec_b[VEC_W +: VEC_W] = {LANES{8'd1}};
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            check("stall_res_data", bus.res_data, 160);
            check("stall_res_id", bus.res_id, 3);
            check("stall_quiet", {bus.res_valid, bus.res_ovf, bus.req_ready, bus.eng_compute}, 7'b1000000);
        end
        to_drive(); bus.res_ready = 1'b1;
        send_txn(1, 1, 8'd1, 8'd1);
        wait_drain();

        // Reset during DRAIN: no result, next transaction starts from zero
        send_txn(0, 1, 8'd9, 8'd9);
        rst = 1'b1; tick(); to_drive(); rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin tick(); seen = seen | bus.res_valid; end
        check("no_result_after_rst", seen, 0);
        check("no_spurious_after_rst", bus.err_spurious, 0);
        exp_q.push_back('{1, 64'd48, 0});
        send_txn(1, 1, 8'd2, 8'd3);
        wait_drain();

        // Spurious engine pulse while idle
        to_drive(); inj_spur = 1'b1; tick(); to_drive(); inj_spur = 1'b0;
        tick();
        check("spurious_flag", bus.err_spurious, 1);
        check("spurious_no_result", bus.res_valid, 0);
        exp_q.push_back('{2, 64'd72, 0});
        send_txn(2, 1, 8'd3, 8'd3);
        wait_drain();
        check("spurious_sticky", bus.err_spurious, 1);

        // ACC_W=19 instance: wrap and overflow flag, then overflow cleared
        send19(2, 8'd255);
        wait_res19();
        check("acc19_data", bus19.res_data, 516112);
        check("acc19_ovf", bus19.res_ovf, 1);
        check("acc19_id", bus19.res_id, 0);
        send19(1, 8'd1);
        wait_res19();
        check("acc19_data2", bus19.res_data, 8);
        check("acc19_ovf2", bus19.res_ovf, 0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
